// File: rtl/rgb_sequence_monitor.sv
// Receive-side checker for the colour-cycling light generator: decodes r/g/b drive
// nibbles, tracks the colour protocol and counts laps and sequence violations.
//
//  state | meaning
//  IDLE  | light off, waiting for RED to start a sequence
//  TRACK | following RED..MAGENTA cycle, dwell counts repeats of current colour
//  FAULT | violation seen, silent until the light goes OFF
module rgb_sequence_monitor #(
   parameter int LAP_W     = 8,
   parameter int ERR_W     = 8,
   parameter int MAX_DWELL = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       r,
   input  logic [3:0]       g,
   input  logic [3:0]       b,
   input  logic             clear,
   output logic [2:0]       color_code,
   output logic             running,
   output logic             seq_error,
   output logic             err_sticky,
   output logic [LAP_W-1:0] lap_count,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

   localparam logic [2:0] C_OFF     = 3'd0;
   localparam logic [2:0] C_RED     = 3'd1;
   localparam logic [2:0] C_YELLOW  = 3'd2;
   localparam logic [2:0] C_GREEN   = 3'd3;
   localparam logic [2:0] C_CYAN    = 3'd4;
   localparam logic [2:0] C_BLUE    = 3'd5;
   localparam logic [2:0] C_MAGENTA = 3'd6;
   localparam logic [2:0] C_INVALID = 3'd7;

   state_t     state;
   logic [3:0] dwell;
   logic [2:0] sample_color;
   logic [2:0] succ_color;
   logic       violation;
   logic       lap_hit;

   always_comb begin
      case ({r, g, b})
         12'h000: sample_color = C_OFF;
         12'hF00: sample_color = C_RED;
         12'hFF0: sample_color = C_YELLOW;
         12'h0F0: sample_color = C_GREEN;
         12'h0FF: sample_color = C_CYAN;
         12'h00F: sample_color = C_BLUE;
         12'hF0F: sample_color = C_MAGENTA;
         default: sample_color = C_INVALID;
      endcase
   end

   // color_code holds the previous sample, so it is the colour being tracked
   assign succ_color = (color_code == C_MAGENTA) ? C_RED : color_code + 3'd1;

   always_comb begin
      violation = 1'b0;
      lap_hit   = 1'b0;
      case (state)
         IDLE: violation = (sample_color != C_OFF) && (sample_color != C_RED);
         TRACK: begin
            if (sample_color == C_OFF) begin
               violation = 1'b0;
            end else if (sample_color == succ_color) begin
               lap_hit = (color_code == C_MAGENTA);
            end else if (sample_color == color_code) begin
               violation = (dwell >= 4'(MAX_DWELL));
            end else begin
               violation = 1'b1;
            end
         end
         default: violation = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         dwell      <= 4'd0;
         color_code <= C_OFF;
         running    <= 1'b0;
         seq_error  <= 1'b0;
         err_sticky <= 1'b0;
         lap_count  <= '0;
         err_count  <= '0;
      end else begin
         color_code <= sample_color;
         seq_error  <= violation;
         case (state)
            IDLE: begin
               if (sample_color == C_RED) begin
                  state   <= TRACK;
                  dwell   <= 4'd1;
                  running <= 1'b1;
               end else begin
                  state   <= violation ? FAULT : IDLE;
                  dwell   <= 4'd0;
                  running <= 1'b0;
               end
            end
            TRACK: begin
               if (sample_color == C_OFF) begin
                  state   <= IDLE;
                  dwell   <= 4'd0;
                  running <= 1'b0;
               end else if (violation) begin
                  state   <= FAULT;
                  dwell   <= 4'd0;
                  running <= 1'b0;
               end else begin
                  state   <= TRACK;
                  dwell   <= (sample_color == color_code) ? dwell + 4'd1 : 4'd1;
                  running <= 1'b1;
               end
            end
            default: begin
               state   <= (sample_color == C_OFF) ? IDLE : FAULT;
               dwell   <= 4'd0;
               running <= 1'b0;
            end
         endcase
         if (lap_hit) lap_count <= lap_count + LAP_W'(1);
         if (violation) begin
            err_sticky <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
         end
         // clear overrides any same-cycle increment or set
         if (clear) begin
            err_sticky <= 1'b0;
            lap_count  <= '0;
            err_count  <= '0;
         end
      end
   end

endmodule

// File: doc/rgb_sequence_monitor.md
Name: rgb_sequence_monitor

Overview:
- Receive-side checker for the colour-cycling light generator.
- Samples the 4-bit r/g/b drive buses every clock and decodes them into a colour code.
- Checks the colour sequence against the protocol: OFF, RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA, then back to RED; any colour may drop to OFF when stopped.
- Reports sequence errors, completed laps and error totals, and sits on the light outputs for self-check and bring-up.

Parameters:
- LAP_W, 8, width of lap counter; wraps modulo 2^LAP_W.
- ERR_W, 8, width of error counter; saturates at all-ones.
- MAX_DWELL, 1, maximum consecutive samples of the same colour allowed while tracking (range 1..15).

Ports:
- clock  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- r  input  4  red drive nibble under observation.
- g  input  4  green drive nibble under observation.
- b  input  4  blue drive nibble under observation.
- clear  input  1  synchronous clear of err_sticky, lap_count and err_count.
- color_code  output  3  decoded colour of the previous sample.
- running  output  1  high while the monitor is in TRACK.
- seq_error  output  1  one-cycle pulse per detected violation.
- err_sticky  output  1  set on any violation, held until clear or reset.
- lap_count  output  LAP_W  completed MAGENTA->RED laps.
- err_count  output  ERR_W  number of violations, saturating.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State=IDLE, previous colour=OFF, dwell=0.
  - All outputs 0: color_code=0 (OFF).
- Decode (combinational on the sample); each nibble must be 0000 or 1111, else INVALID:
  - OFF=0 (r=0,g=0,b=0)
  - RED=1 (F,0,0)
  - YELLOW=2 (F,F,0)
  - GREEN=3 (0,F,0)
  - CYAN=4 (0,F,F)
  - BLUE=5 (0,0,F)
  - MAGENTA=6 (F,0,F)
  - INVALID=7 (any other combination, including F,F,F)
- Latency:
  - Sample at edge N appears on color_code after edge N, i.e. 1-cycle latency.
  - seq_error, running, lap_count and err_count update on the same edge as the colour they relate to.
- Successor of colour k (1..5) is k+1; successor of MAGENTA(6) is RED(1).
- State IDLE:
  - OFF -> stay IDLE.
  - RED -> TRACK, dwell=1.
  - Any other colour or INVALID -> violation, go to FAULT.
- State TRACK:
  - OFF -> IDLE, no error (legal stop).
  - Successor colour -> stay TRACK, dwell=1.
  - Same colour with dwell<MAX_DWELL -> stay, dwell+1.
  - Same colour with dwell==MAX_DWELL -> violation (stuck), go to FAULT.
  - Any other colour or INVALID -> violation, go to FAULT.
- State FAULT:
  - OFF -> IDLE.
  - Anything else -> stay FAULT with no further seq_error pulses (one pulse per fault episode).
- Violation effects:
  - seq_error=1 for exactly one cycle.
  - err_sticky<=1.
  - err_count+1, saturating at 2^ERR_W-1.
- Lap counting: MAGENTA->RED accepted in TRACK -> lap_count+1, wrapping from 2^LAP_W-1 to 0.
- running=1 exactly when the next state is TRACK (registered).
- dwell: 4-bit counter; only meaningful in TRACK; cleared in IDLE/FAULT.
- Clear:
  - clear==1 zeroes err_sticky, lap_count and err_count; clear wins over a same-cycle increment or set.
  - A same-cycle seq_error pulse is still emitted.
  - Clear does not change state, color_code or running.
- Reset mid-sequence or mid-fault returns everything to reset values on that edge. reset has priority over clear.

Test Plan:
- Reset low 2 cycles, then drive OFF for 3 cycles -> color_code=0, running=0, every counter 0, seq_error never asserted.
- Drive OFF, RED, YELLOW, GREEN, CYAN, BLUE, MAGENTA, RED, YELLOW, then OFF -> color_code follows 0,1,2,3,4,5,6,1,2,0; running high for 8 cycles; lap_count=1 after the second RED; no errors.
- Jump to GREEN right after RED -> single seq_error pulse and err_count=1, err_sticky=1. Hold GREEN 5 more cycles -> no further pulses. Then OFF -> IDLE; then RED -> running=1.
- MAX_DWELL=2: RED, RED -> no error. RED, RED, RED -> seq_error on the third RED.
- Drive r=4'b0101 while in IDLE -> color_code=7, seq_error pulse. Assert clear on the same cycle as the next violation -> seq_error pulses, err_count=0, err_sticky=0.
- Run 256 laps with LAP_W=8 -> lap_count wraps to 0. Force 300 violations (one per fault episode) -> err_count saturates at 255. Assert reset mid-lap -> all outputs 0 on the next cycle.
